// File: rtl/particle_streamer_pkg.sv
// Shared definitions for the particle streaming path: record layout,
// streamer states and default sizing.
package defs;

   localparam int NUM_PARTICLES  = 32;
   localparam int DATA_W         = 128;
   localparam int PARTICLE_BYTES = DATA_W / 8;

   // One particle record as it sits in external memory.
   typedef struct packed {
      logic [DATA_W/4-1:0] pos_x;
      logic [DATA_W/4-1:0] pos_y;
      logic [DATA_W/4-1:0] pos_z;
      logic [DATA_W/4-1:0] weight;
   } particle_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } streamer_state_t;

endpackage

// File: rtl/particle_streamer_fifo.sv
// Synchronous FIFO with a registered head. The head register always holds
// the oldest entry, so the output comes straight from a flop. Push and pop
// may coincide at any occupancy, including full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
   logic             full, do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign do_push = push && (!full || do_pop);
   assign rd_next = rd_ptr + 1'b1;

   // Storage array; validity is tracked by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers, occupancy and the head register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_next;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         if (do_pop) begin
            // When full, the push overwrites the slot being popped, never
            // the one that becomes the new head.
            if (count > CNT_W'(1)) head <= mem[rd_next];
            else if (do_push)      head <= push_data;
         end else if (empty && do_push) begin
            head <= push_data;
         end
      end
   end

endmodule

// File: rtl/particle_streamer.sv
// Streams NUM_PARTICLES records per phase from external memory to the
// push/scatter datapath. Reads are issued only while the response buffer
// has a guaranteed slot, so unthrottled responses can never overflow it.
module particle_streamer #(
   parameter int NUM_PARTICLES = defs::NUM_PARTICLES,
   parameter int DATA_W        = 128,
   parameter int ADDR_W        = 28,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              rsp_err
);

   import defs::*;

   localparam int                IDX_W    = $clog2(NUM_PARTICLES+1);
   localparam int                CNT_W    = $clog2(FIFO_DEPTH+1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(DATA_W/8);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PARTICLES-1);
   localparam logic [IDX_W-1:0]  REQ_END  = IDX_W'(NUM_PARTICLES);
   localparam logic [CNT_W:0]    CREDITS  = (CNT_W+1)'(FIFO_DEPTH);

   streamer_state_t   state, state_nxt;
   logic [IDX_W-1:0]  req_idx, out_idx;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  outstanding, fifo_count;
   logic [CNT_W:0]    credit_used;
   logic              start_ok, req_fire, out_fire, last_fire, rsp_push;
   logic              fifo_empty, done_q, rsp_err_q;

   assign start_ok    = start && (state == IDLE);
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign req_fire    = mem_req_valid && mem_req_ready;
   assign out_fire    = out_valid && out_ready;
   assign last_fire   = out_fire && (out_idx == LAST_IDX);
   // Responses in IDLE belong to an aborted phase and are discarded.
   assign rsp_push    = mem_rsp_valid && (state != IDLE);

   assign mem_req_addr = addr;
   assign out_valid    = !fifo_empty;
   assign out_last     = out_valid && (out_idx == LAST_IDX);
   assign busy         = (state != IDLE);
   assign done         = done_q;
   assign rsp_err      = rsp_err_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and request issue. Requests stop once all indices are
   // issued, covering the single RUN cycle before the move to DRAIN.
   always_comb begin
      state_nxt     = state;
      mem_req_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            mem_req_valid = (req_idx != REQ_END) && (credit_used < CREDITS);
            if (last_fire)               state_nxt = IDLE;
            else if (req_idx == REQ_END) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (last_fire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters, address, credit tracking and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_idx     <= '0;
         out_idx     <= '0;
         addr        <= '0;
         outstanding <= '0;
         done_q      <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         done_q <= last_fire;
         if (mem_rsp_valid && (state == IDLE)) rsp_err_q <= 1'b1;
         if (start_ok) begin
            req_idx <= '0;
            out_idx <= '0;
            addr    <= base_addr;
         end else begin
            if (req_fire) begin
               req_idx <= req_idx + 1'b1;
               addr    <= addr + STEP;
            end
            if (out_fire) out_idx <= out_idx + 1'b1;
         end
         unique case ({req_fire, rsp_push})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rsp_push),
      .push_data (mem_rsp_data),
      .pop       (out_fire),
      .head      (out_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule
